// File: rtl/mem_stage_io.sv
// MEM-stage access unit: data RAM plus memory-mapped timer, LED, 7-segment and systick registers.
// Loads are combinational; stores and all register updates commit on the rising clock edge.
module mem_stage_io #(
  parameter int DM_WORDS = 256,
  parameter int DM_AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  localparam logic [29:0] WORD_TH      = 30'h1000_0000;
  localparam logic [29:0] WORD_TL      = 30'h1000_0001;
  localparam logic [29:0] WORD_TCON    = 30'h1000_0002;
  localparam logic [29:0] WORD_LED     = 30'h1000_0003;
  localparam logic [29:0] WORD_DIGI    = 30'h1000_0004;
  localparam logic [29:0] WORD_SYSTICK = 30'h1000_0005;

  logic [31:0] mem [DM_WORDS];
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  logic [DM_AW-1:0] ram_idx;
  logic             sel_ram;
  logic             sel_th;
  logic             sel_tl;
  logic             sel_tcon;
  logic             sel_led;
  logic             sel_digi;
  logic             sel_systick;
  logic             unused_addr_bits;

  // Byte offset within the word is irrelevant: all accesses are full words.
  assign unused_addr_bits = ^addr[1:0];

  assign ram_idx     = addr[DM_AW+1:2];
  assign sel_ram     = (addr[31:DM_AW+2] == '0);
  assign sel_th      = (addr[31:2] == WORD_TH);
  assign sel_tl      = (addr[31:2] == WORD_TL);
  assign sel_tcon    = (addr[31:2] == WORD_TCON);
  assign sel_led     = (addr[31:2] == WORD_LED);
  assign sel_digi    = (addr[31:2] == WORD_DIGI);
  assign sel_systick = (addr[31:2] == WORD_SYSTICK);

  always_ff @(posedge clk) begin
    if (!reset && mem_write && sel_ram) begin
      mem[ram_idx] <= wdata;
    end
  end

  // Timer update comes first so a CPU write later in the block overrides it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;

      if (tcon[0]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[1]) begin
            tcon[2] <= 1'b1;
          end
        end else begin
          tl <= tl + 32'd1;
        end
      end

      if (mem_write) begin
        if (sel_th) begin
          th <= wdata;
        end
        if (sel_tl) begin
          tl <= wdata;
        end
        if (sel_tcon) begin
          tcon <= wdata[2:0];
        end
        if (sel_led) begin
          led <= wdata[7:0];
        end
        if (sel_digi) begin
          digi <= wdata[11:0];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (mem_read) begin
      if (sel_ram) begin
        rdata = mem[ram_idx];
      end else if (sel_th) begin
        rdata = th;
      end else if (sel_tl) begin
        rdata = tl;
      end else if (sel_tcon) begin
        rdata = {29'd0, tcon};
      end else if (sel_led) begin
        rdata = {24'd0, led};
      end else if (sel_digi) begin
        rdata = {20'd0, digi};
      end else if (sel_systick) begin
        rdata = systick;
      end
    end
  end

  assign irq = tcon[1] & tcon[2];

endmodule

// File: tb/tb_mem_stage_io.sv
// Bench for mem_stage_io: directed scenarios followed by random traffic, all checked
// against a register-level reference model of the memory map kept in the bench.
module tb_mem_stage_io;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [31:0] mRam [256];
  bit          mValid [256];
  logic [31:0] mTh      = 0;
  logic [31:0] mTl      = 0;
  logic [2:0]  mTcon    = 0;
  logic [7:0]  mLed     = 0;
  logic [11:0] mDigi    = 0;
  logic [31:0] mSystick = 0;

  logic [31:0] lastRdata;
  logic        lastIrq;
  logic [7:0]  lastLed;
  logic [11:0] lastDigi;

  mem_stage_io #(.DM_WORDS(256), .DM_AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .led       (led),
    .digi      (digi),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive after the falling edge, check the combinational view, then advance the model.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic rst);
    logic [31:0] expRdata;
    logic [31:0] nTl;
    logic [2:0]  nTcon;
    bit          known;
    @(negedge clk);
    reset     = rst;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    #1;
    expRdata = 32'd0;
    known    = 1'b1;
    if (rd) begin
      if (a < 32'h400) begin
        known    = mValid[a[9:2]];
        expRdata = mRam[a[9:2]];
      end else begin
        case (a & 32'hFFFF_FFFC)
          32'h4000_0000: expRdata = mTh;
          32'h4000_0004: expRdata = mTl;
          32'h4000_0008: expRdata = 32'(mTcon);
          32'h4000_000C: expRdata = 32'(mLed);
          32'h4000_0010: expRdata = 32'(mDigi);
          32'h4000_0014: expRdata = mSystick;
          default:       expRdata = 32'd0;
        endcase
      end
    end
    lastRdata = rdata;
    lastIrq   = irq;
    lastLed   = led;
    lastDigi  = digi;
    if (known) checkOutput($sformatf("rdata@%08h", a), rdata, expRdata);
    checkOutput("irq", 32'(irq), 32'(mTcon[1] & mTcon[2]));
    checkOutput("led", 32'(led), 32'(mLed));
    checkOutput("digi", 32'(digi), 32'(mDigi));
    @(posedge clk);
    if (rst) begin
      mTh = 0; mTl = 0; mTcon = 0; mLed = 0; mDigi = 0; mSystick = 0;
    end else begin
      mSystick = mSystick + 1;
      nTl   = mTl;
      nTcon = mTcon;
      if (mTcon[0]) begin
        if (mTl == 32'hFFFF_FFFF) begin
          nTl = mTh;
          if (mTcon[1]) nTcon[2] = 1'b1;
        end else begin
          nTl = mTl + 1;
        end
      end
      if (wr) begin
        if (a < 32'h400) begin
          mRam[a[9:2]]   = d;
          mValid[a[9:2]] = 1'b1;
        end else begin
          case (a & 32'hFFFF_FFFC)
            32'h4000_0000: mTh   = d;
            32'h4000_0004: nTl   = d;
            32'h4000_0008: nTcon = d[2:0];
            32'h4000_000C: mLed  = d[7:0];
            32'h4000_0010: mDigi = d[11:0];
            default: ;
          endcase
        end
      end
      mTl   = nTl;
      mTcon = nTcon;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    repeat (2) @(posedge clk);

    // Out of reset: idle five cycles, then systick reads 5
    repeat (5) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h4000_0014, 32'd0, 1'b0);
    checkOutput("systick_after_reset", lastRdata, 32'd5);
    checkOutput("led_after_reset", 32'(lastLed), 32'd0);
    checkOutput("digi_after_reset", 32'(lastDigi), 32'd0);
    checkOutput("irq_after_reset", 32'(lastIrq), 32'd0);

    // RAM store/load, byte offset ignored, unmapped reads zero
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    checkOutput("ram_load", lastRdata, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'h0000_0011, 32'd0, 1'b0);
    checkOutput("ram_load_offset", lastRdata, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'h5000_0000, 32'd0, 1'b0);
    checkOutput("unmapped_load", lastRdata, 32'd0);

    // Read and write in the same cycle return the old word
    applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h2, 1'b0);
    checkOutput("rmw_old_value", lastRdata, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0);
    checkOutput("rmw_new_value", lastRdata, 32'h2);

    // Timer overflow, reload and interrupt
    applyStimulus(1'b0, 1'b1, 32'h4000_0000, 32'hFFFF_FFFC, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h4000_0004, 32'hFFFF_FFFE, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h4000_0008, 32'h3, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h4000_0004, 32'd0, 1'b0);
    checkOutput("tl_enabled", lastRdata, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 1'b0, 32'h4000_0004, 32'd0, 1'b0);
    checkOutput("tl_max", lastRdata, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 32'h4000_0004, 32'd0, 1'b0);
    checkOutput("tl_reload", lastRdata, 32'hFFFF_FFFC);
    checkOutput("irq_on_overflow", 32'(lastIrq), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h4000_0008, 32'd0, 1'b0);
    checkOutput("tcon_overflow", lastRdata, 32'h7);
    applyStimulus(1'b0, 1'b1, 32'h4000_0008, 32'h3, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h4000_0008, 32'd0, 1'b0);
    checkOutput("tcon_cleared", lastRdata, 32'h3);
    checkOutput("irq_cleared", 32'(lastIrq), 32'd0);

    // CPU write to TL in the overflow cycle wins, status bit still sets
    applyStimulus(1'b0, 1'b1, 32'h4000_0004, 32'hFFFF_FFFE, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h4000_0004, 32'd0, 1'b0);
    checkOutput("tl_preset", lastRdata, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 1'b1, 32'h4000_0004, 32'h100, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h4000_0004, 32'd0, 1'b0);
    checkOutput("tl_write_wins", lastRdata, 32'h100);
    checkOutput("irq_write_overflow", 32'(lastIrq), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h4000_0008, 32'd0, 1'b0);
    checkOutput("tcon_write_overflow", lastRdata, 32'h7);

    // LED/DIGI then reset; RAM survives
    applyStimulus(1'b0, 1'b1, 32'h4000_000C, 32'hA5, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h4000_0010, 32'h3F6, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h4000_0010, 32'd0, 1'b0);
    checkOutput("led_written", 32'(lastLed), 32'hA5);
    checkOutput("digi_written", lastRdata, 32'h3F6);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h4000_0008, 32'd0, 1'b0);
    checkOutput("tcon_after_reset", lastRdata, 32'd0);
    checkOutput("led_cleared", 32'(lastLed), 32'd0);
    checkOutput("digi_cleared", 32'(lastDigi), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    checkOutput("ram_survives_reset", lastRdata, 32'hDEAD_BEEF);

    // Random traffic biased toward the timer registers and counter wrap values
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        3:       a = 32'h0000_03FC;
        9:       a = $urandom;
        default: a = 32'h4000_0000 + ($urandom_range(0, 6) << 2) + $urandom_range(0, 3);
      endcase
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'hFFFF_FFFF - $urandom_range(0, 8);
        2:       d = $urandom_range(0, 7);
        default: d = $urandom;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, d,
                    ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
